// File: rtl/alu_operand_muxes_pkg.sv
// Shared constants for the EX-stage operand-selection block: default widths and forward-select codes.
package alu_operand_muxes_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_REG_W  = 3;
  localparam int unsigned FWD_W          = 2;

  localparam logic [FWD_W-1:0] FWD_REG     = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB      = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM     = 2'b10;
  localparam logic [FWD_W-1:0] FWD_ILLEGAL = 2'b11;

  function automatic logic isIllegalFwd(input logic [FWD_W-1:0] fwdSel);
    return fwdSel == FWD_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_operand_muxes_fwd_mux3.sv
// 3-way forwarding mux: register file, WB write data or MEM ALU result.
// The reserved code falls back to the register-file value and is flagged.
module fwd_mux3
  import alu_operand_muxes_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [FWD_W-1:0]  fwdSel,
  input  logic [DATA_W-1:0] regVal,
  input  logic [DATA_W-1:0] wbVal,
  input  logic [DATA_W-1:0] memVal,
  output logic [DATA_W-1:0] fwdOut_c,
  output logic              illegal_c
);

  always_comb begin
    fwdOut_c  = regVal;
    illegal_c = 1'b0;
    case (fwdSel)
      FWD_WB:  fwdOut_c = wbVal;
      FWD_MEM: fwdOut_c = memVal;
      default: illegal_c = isIllegalFwd(fwdSel);
    endcase
  end

endmodule

// File: rtl/alu_operand_muxes.sv
// EX-stage destination select and ALU operand forwarding with a sticky illegal-select flag.
// Define ALU_MUX_PIPE_OUT_EN to register DestReg/Operand1/Operand2/StoreData (one-cycle latency).
module alu_operand_muxes
  import alu_operand_muxes_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned REG_W  = DEFAULT_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegDst,
  input  logic [REG_W-1:0]  Rt,
  input  logic [REG_W-1:0]  Rd,
  output logic [REG_W-1:0]  DestReg,
  input  logic              ALUSrc,
  input  logic [FWD_W-1:0]  ForwardA,
  input  logic [FWD_W-1:0]  ForwardB,
  input  logic [DATA_W-1:0] Mem_ALUOut,
  input  logic [DATA_W-1:0] WB_WriteData,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] Operand1,
  output logic [DATA_W-1:0] Operand2,
  output logic [DATA_W-1:0] StoreData,
  output logic              FwdErr
);

  logic [REG_W-1:0]  destReg_c;
  logic [DATA_W-1:0] fwdA_c;
  logic [DATA_W-1:0] fwdB_c;
  logic [DATA_W-1:0] operand2_c;
  logic              illegalA_c;
  logic              illegalB_c;

  fwd_mux3 #(.DATA_W(DATA_W)) uFwdA (
    .fwdSel    (ForwardA),
    .regVal    (ReadData1),
    .wbVal     (WB_WriteData),
    .memVal    (Mem_ALUOut),
    .fwdOut_c  (fwdA_c),
    .illegal_c (illegalA_c)
  );

  fwd_mux3 #(.DATA_W(DATA_W)) uFwdB (
    .fwdSel    (ForwardB),
    .regVal    (ReadData2),
    .wbVal     (WB_WriteData),
    .memVal    (Mem_ALUOut),
    .fwdOut_c  (fwdB_c),
    .illegal_c (illegalB_c)
  );

  // Immediate overrides operand 2 even when ForwardB is illegal; the flag still records it.
  always_comb begin
    destReg_c  = RegDst ? Rd : Rt;
    operand2_c = ALUSrc ? Imm : fwdB_c;
  end

  // Sticky illegal-forward flag; reset wins over a same-edge illegal code.
  always_ff @(posedge clk) begin
    if (rst) begin
      FwdErr <= 1'b0;
    end else if (illegalA_c || illegalB_c) begin
      FwdErr <= 1'b1;
    end
  end

`ifdef ALU_MUX_PIPE_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      DestReg   <= '0;
      Operand1  <= '0;
      Operand2  <= '0;
      StoreData <= '0;
    end else begin
      DestReg   <= destReg_c;
      Operand1  <= fwdA_c;
      Operand2  <= operand2_c;
      StoreData <= fwdB_c;
    end
  end
`else
  always_comb begin
    DestReg   = destReg_c;
    Operand1  = fwdA_c;
    Operand2  = operand2_c;
    StoreData = fwdB_c;
  end
`endif

endmodule

// File: tb/tb_alu_operand_muxes.sv
// Scoreboard bench for alu_operand_muxes: driver pushes model expectations, negedge monitor pops and compares.
module tb_alu_operand_muxes;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
`ifdef ALU_MUX_PIPE_OUT_EN
  localparam int DATA_LAT = 1;
`else
  localparam int DATA_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          RegDst;
  logic [RW-1:0] Rt, Rd, DestReg;
  logic          ALUSrc;
  logic [1:0]    ForwardA, ForwardB;
  logic [DW-1:0] Mem_ALUOut, WB_WriteData, ReadData1, ReadData2, Imm;
  logic [DW-1:0] Operand1, Operand2, StoreData;
  logic          FwdErr;

  alu_operand_muxes dut (
    .clk          (clk),
    .rst          (rst),
    .RegDst       (RegDst),
    .Rt           (Rt),
    .Rd           (Rd),
    .DestReg      (DestReg),
    .ALUSrc       (ALUSrc),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .Mem_ALUOut   (Mem_ALUOut),
    .WB_WriteData (WB_WriteData),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .Imm          (Imm),
    .Operand1     (Operand1),
    .Operand2     (Operand2),
    .StoreData    (StoreData),
    .FwdErr       (FwdErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] dest;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] store;
  } dataExp_t;

  dataExp_t dataQ[$];
  bit       errQ[$];
  bit       errModel = 1'b0;
  int       vectors = 0;
  int       miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and enqueue what the design must show for it.
  task automatic drive(input bit r, input bit regDst, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input bit aluSrc, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [DW-1:0] mem, input logic [DW-1:0] wb,
                       input logic [DW-1:0] rd1, input logic [DW-1:0] rd2, input logic [DW-1:0] imm);
    logic [DW-1:0] srcA[4];
    logic [DW-1:0] srcB[4];
    dataExp_t e;
    @(posedge clk);
    #1;
    rst = r; RegDst = regDst; Rt = rt; Rd = rd; ALUSrc = aluSrc;
    ForwardA = fa; ForwardB = fb; Mem_ALUOut = mem; WB_WriteData = wb;
    ReadData1 = rd1; ReadData2 = rd2; Imm = imm;
    // Code 0 and the reserved code 3 both read the register file.
    srcA = '{rd1, wb, mem, rd1};
    srcB = '{rd2, wb, mem, rd2};
    e.dest  = regDst ? rd : rt;
    e.op1   = srcA[fa];
    e.store = srcB[fb];
    e.op2   = aluSrc ? imm : srcB[fb];
    if (DATA_LAT == 1 && r) begin
      e.dest = '0; e.op1 = '0; e.op2 = '0; e.store = '0;
    end
    dataQ.push_back(e);
    errModel = r ? 1'b0 : (errModel | (fa == 2'b11) | (fb == 2'b11));
    errQ.push_back(errModel);
  endtask

  task automatic driveFixed(input bit r, input bit regDst, input bit aluSrc,
                            input logic [1:0] fa, input logic [1:0] fb);
    drive(r, regDst, 3'd1, 3'd2, aluSrc, fa, fb, 16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222, 16'hFFFF);
  endtask

  // Monitor: data appears DATA_LAT cycles after drive, FwdErr one edge after drive.
  always @(negedge clk) begin
    if (dataQ.size() > DATA_LAT) begin
      dataExp_t e;
      e = dataQ.pop_front();
      chk("DestReg", DW'(DestReg), DW'(e.dest));
      chk("Operand1", Operand1, e.op1);
      chk("Operand2", Operand2, e.op2);
      chk("StoreData", StoreData, e.store);
    end
    if (errQ.size() > 1) begin
      bit ee;
      ee = errQ.pop_front();
      chk("FwdErr", DW'(FwdErr), DW'(ee));
    end
  end

  initial begin
    rst = 1'b1; RegDst = 1'b0; Rt = '0; Rd = '0; ALUSrc = 1'b0;
    ForwardA = '0; ForwardB = '0; Mem_ALUOut = '0; WB_WriteData = '0;
    ReadData1 = '0; ReadData2 = '0; Imm = '0;

    driveFixed(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b1, 1'b1, 2'b00, 2'b01);
    driveFixed(1'b0, 1'b1, 1'b0, 2'b10, 2'b01);
    driveFixed(1'b0, 1'b1, 1'b0, 2'b01, 2'b10);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b1, 1'b0, 1'b0, 2'b00, 2'b11);
    driveFixed(1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
    driveFixed(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    driveFixed(1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), 1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
            2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom));
    end
    driveFixed(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_muxes.md
Name: alu_operand_muxes

Overview:
Execute-stage operand-selection block of the 16-bit pipelined processor. It picks the destination register (Rt or Rd) and forwards ALU operands from the register file, the MEM-stage ALU result or the WB-stage write data. It also applies the immediate on operand 2. The datapath is combinational; the clock and reset only drive a sticky illegal-select flag and the optional output register stage.

Parameters:
DATA_W, 16, width of data operands and results
REG_W, 3, width of register specifiers

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
RegDst  in  1  1 selects Rd, 0 selects Rt as destination
Rt  in  REG_W  rt field of the EX instruction
Rd  in  REG_W  rd field of the EX instruction
DestReg  out  REG_W  selected destination register
ALUSrc  in  1  1 selects Imm for Operand2
ForwardA  in  2  forward select for operand A
ForwardB  in  2  forward select for operand B
Mem_ALUOut  in  DATA_W  ALU result held in EX/MEM
WB_WriteData  in  DATA_W  write-back data from MEM/WB
ReadData1  in  DATA_W  register-file rs value
ReadData2  in  DATA_W  register-file rt value
Imm  in  DATA_W  sign-extended immediate
Operand1  out  DATA_W  ALU input A
Operand2  out  DATA_W  ALU input B
StoreData  out  DATA_W  forwarded B value before the ALUSrc mux (store data)
FwdErr  out  1  sticky flag: an illegal forward code was seen

Behaviour:
- One clock: clk. Reset is synchronous and active-high on rst.
- DestReg = RegDst ? Rd : Rt.
- Forward encoding, applied to ForwardA and ForwardB:
  - 00 selects the register-file value (ReadData1 for A, ReadData2 for B).
  - 01 selects WB_WriteData.
  - 10 selects Mem_ALUOut.
  - 11 is illegal and falls back to the register-file value.
- Operand1 = forwarded A.
- StoreData = forwarded B.
- Operand2 = ALUSrc ? Imm : forwarded B.
- Outputs are purely combinational with zero latency. They are unaffected by rst.
- No arithmetic is performed and no width conversion occurs; all data paths are DATA_W bits.
- FwdErr:
  - Reset value 0.
  - On each rising clk edge with rst=0, FwdErr is set to 1 if ForwardA==11 or ForwardB==11.
  - Once set, FwdErr stays 1 until rst.
  - rst has priority over a simultaneous illegal code; FwdErr=0 after that edge.
- ForwardB==11 with ALUSrc=1: Operand2 is still Imm, and FwdErr still sets.

Optional Feature:
Macro ALU_MUX_PIPE_OUT_EN.
- Defined:
  - DestReg, Operand1, Operand2 and StoreData are registered on clk, giving one-cycle latency.
  - All four reset synchronously to 0.
  - FwdErr behaviour is unchanged.
- Undefined: the outputs are combinational, as described in Behaviour.

Decomposition:
- Shared package holds the forward-select constants:
  - FWD_REG = 2'b00
  - FWD_WB = 2'b01
  - FWD_MEM = 2'b10
- The package also holds the DATA_W and REG_W defaults.
- One natural sub-module, fwd_mux3: a 3-way forward mux with illegal-code fallback, instantiated for A and for B.

Test Plan:
All scenarios use Rt=1, Rd=2, ReadData1=1111, ReadData2=2222, Mem_ALUOut=AAAA, WB_WriteData=BBBB, Imm=FFFF (hex).
- RegDst=0, ALUSrc=0, ForwardA=00, ForwardB=00 -> DestReg=001, Operand1=1111, Operand2=2222, StoreData=2222.
- RegDst=1, ALUSrc=1, ForwardB=01 -> DestReg=010, Operand1=1111, Operand2=FFFF, StoreData=BBBB.
- ALUSrc=0, ForwardA=10, ForwardB=01 -> Operand1=AAAA, Operand2=BBBB.
- ForwardA=01, ForwardB=10 -> Operand1=BBBB, Operand2=AAAA. Then RegDst=0 with both selects 00 -> DestReg=001, Operand1=1111, Operand2=2222.
- Illegal-code and reset:
  - Pulse rst -> FwdErr=0.
  - ForwardA=11 for one edge -> Operand1=1111, FwdErr=1 and stays 1 after the select returns to 00.
  - rst with ForwardB=11 on the same edge -> FwdErr=0.
- With ALU_MUX_PIPE_OUT_EN defined:
  - ForwardA changed 00->10 -> Operand1 shows AAAA one clk after the change.
  - rst -> all registered outputs read 0.
